// File: rtl/barycentric_interpolate.sv
// Barycentric reconstruction: p = u*a + v*b + w*c.
// Uses one shared multiplier and one accumulator over nine MAC cycles.
module barycentric_interpolate #(
  parameter int COORD_WIDTH = 32,
  parameter int FRAC_BITS   = 16
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic signed [2:0][COORD_WIDTH-1:0] a,
  input  logic signed [2:0][COORD_WIDTH-1:0] b,
  input  logic signed [2:0][COORD_WIDTH-1:0] c,
  input  logic                               init,
  output logic                               init_done,
  input  logic signed [COORD_WIDTH-1:0]      u,
  input  logic signed [COORD_WIDTH-1:0]      v,
  input  logic signed [COORD_WIDTH-1:0]      w,
  input  logic                               valid_in,
  output logic signed [2:0][COORD_WIDTH-1:0] p,
  output logic                               valid,
  output logic                               busy
);

  localparam int W  = COORD_WIDTH;
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 2;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [2:0][W-1:0] a_q, b_q, c_q;
  logic [W-1:0]      u_q, v_q, w_q;
  logic [1:0][W-1:0] stg_q;
  logic [2:0][W-1:0] p_q;
  logic signed [AW-1:0] acc_q;

  logic take_init, take_req;
  logic in_mac, last_term, last_cnt;
  logic [1:0] axis, term;
  logic [2:0][W-1:0] vtx;
  logic signed [W-1:0]  wsel, vsel;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum, sh;
  logic [AW-W:0] hi;
  logic [W-1:0]  sat;

  assign take_init = (state_q == IDLE) && init;
  assign take_req  = (state_q == IDLE) && !init && valid_in;
  assign in_mac    = (state_q == MAC);
  assign last_term = (term == 2'd2);
  assign last_cnt  = (cnt_q == 4'd8);

  always_comb begin
    axis = 2'd2;
    term = 2'd2;
    unique case (cnt_q)
      4'd0, 4'd1, 4'd2: axis = 2'd0;
      4'd3, 4'd4, 4'd5: axis = 2'd1;
      default:          axis = 2'd2;
    endcase
    unique case (cnt_q)
      4'd0, 4'd3, 4'd6: term = 2'd0;
      4'd1, 4'd4, 4'd7: term = 2'd1;
      default:          term = 2'd2;
    endcase
  end

  // term picks the (weight, vertex) pair, axis picks the coordinate
  always_comb begin
    wsel = w_q;
    vtx  = c_q;
    unique case (term)
      2'd0: begin
        wsel = u_q;
        vtx  = a_q;
      end
      2'd1: begin
        wsel = v_q;
        vtx  = b_q;
      end
      default: begin
        wsel = w_q;
        vtx  = c_q;
      end
    endcase
    vsel = vtx[2];
    unique case (axis)
      2'd0:    vsel = vtx[0];
      2'd1:    vsel = vtx[1];
      default: vsel = vtx[2];
    endcase
  end

  assign prod = wsel * vsel;
  assign sum  = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
  assign sh   = sum >>> FRAC_BITS;
  assign hi   = sh[AW-1:W-1];

  always_comb begin
    sat = sh[W-1:0];
    if (!((&hi) || (~|hi))) begin
      if (sh[AW-1]) sat = {1'b1, {(W-1){1'b0}}};
      else          sat = {1'b0, {(W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (take_req) state_d = MAC;
      end
      MAC: begin
        cnt_d = cnt_q + 4'd1;
        if (last_cnt) state_d = OUT;
      end
      OUT: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= take_init;
      if (take_init) begin
        a_q <= a;
        b_q <= b;
        c_q <= c;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      u_q <= '0;
      v_q <= '0;
      w_q <= '0;
    end else if (take_req) begin
      u_q <= u;
      v_q <= v;
      w_q <= w;
    end
  end

  // Axes 0 and 1 wait in stg_q so all of p changes in one cycle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q <= '0;
      stg_q <= '0;
      p_q   <= '0;
    end else if (in_mac) begin
      acc_q <= last_term ? '0 : sum;
      if (last_term && axis == 2'd0) stg_q[0] <= sat;
      if (last_term && axis == 2'd1) stg_q[1] <= sat;
      if (last_cnt) p_q <= {sat, stg_q[1], stg_q[0]};
    end
  end

  assign p     = p_q;
  assign valid = (state_q == OUT);
  assign busy  = (state_q != IDLE);

endmodule
